// File: rtl/vec_capture_pkg.sv
// Shared types and default sizing for the vector capture buffer.
package vec_capture_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_DEPTH = 16;

    // CAPTURE: accepting bus words; FULL: buffer at capacity; DUMP: replaying the image
    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FULL    = 2'd1,
        DUMP    = 2'd2
    } state_t;

endpackage

// File: rtl/vec_capture_mem_if.sv
// Capture-side bus, replay stream and status of the vector capture buffer.
interface vec_capture_mem_if
    import vec_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             dump_req;
    logic             dump_valid;
    logic             dump_ready;
    logic [AW-1:0]    dump_addr;
    logic [WIDTH-1:0] dump_data;
    logic [AW:0]      count;
    logic             full;
    logic             overflow;

    // Environment side: drives the strobe bus and consumes the replay
    modport master (
        output in_valid, in_data, dump_req, dump_ready,
        input  in_ready, dump_valid, dump_addr, dump_data, count, full, overflow
    );

    // Buffer side
    modport slave (
        input  in_valid, in_data, dump_req, dump_ready,
        output in_ready, dump_valid, dump_addr, dump_data, count, full, overflow
    );
endinterface

// File: rtl/vec_capture_ram.sv
// DEPTH x WIDTH storage: one write port, one registered read port with read enable.
// The read register keeps its value while re is low so a stalled replay beat stays put.
module vec_capture_ram
    import vec_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    // Storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read, cleared by reset so the replay word starts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/vec_capture_mem.sv
// Vector capture buffer: stores strobed bus words at sequential addresses and
// replays the captured image, address 0 upward, on a dump request.
module vec_capture_mem
    import vec_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    vec_capture_mem_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_reg, state_next;
    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW:0]   rptr_reg, rptr_next;     // next replay address to fetch
    logic          overflow_reg, overflow_next;
    logic          dump_valid_reg, dump_valid_next;
    logic [AW-1:0] dump_addr_reg, dump_addr_next;
    logic          we;
    logic          re;
    logic [WIDTH-1:0] rdata;

    // Next-state logic: capture/full bookkeeping and the replay fetch pipeline
    always_comb begin
        state_next      = state_reg;
        wptr_next       = wptr_reg;
        count_next      = count_reg;
        rptr_next       = rptr_reg;
        overflow_next   = overflow_reg;
        dump_valid_next = dump_valid_reg;
        dump_addr_next  = dump_addr_reg;
        we              = 1'b0;
        re              = 1'b0;
        case (state_reg)
            CAPTURE: begin
                if (bus.in_valid) begin
                    we         = 1'b1;
                    wptr_next  = wptr_reg + 1'b1;
                    count_next = count_reg + 1'b1;
                    if (count_reg == DEPTH_C - 1'b1) begin
                        state_next = FULL;
                    end
                end
                // The same-cycle write lands in RAM before the first replay read
                if (bus.dump_req) begin
                    state_next = DUMP;
                    rptr_next  = '0;
                end
            end
            FULL: begin
                if (bus.in_valid) begin
                    overflow_next = 1'b1;
                end
                if (bus.dump_req) begin
                    state_next = DUMP;
                    rptr_next  = '0;
                end
            end
            DUMP: begin
                // Advance only when the output slot is empty or being consumed
                if (!dump_valid_reg || bus.dump_ready) begin
                    if (rptr_reg != count_reg) begin
                        re              = 1'b1;
                        rptr_next       = rptr_reg + 1'b1;
                        dump_valid_next = 1'b1;
                        dump_addr_next  = rptr_reg[AW-1:0];
                    end else begin
                        // Last beat gone (or nothing captured): buffer is emptied
                        dump_valid_next = 1'b0;
                        state_next      = CAPTURE;
                        count_next      = '0;
                        wptr_next       = '0;
                        rptr_next       = '0;
                        overflow_next   = 1'b0;
                    end
                end
            end
            default: state_next = CAPTURE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= CAPTURE;
            wptr_reg       <= '0;
            count_reg      <= '0;
            rptr_reg       <= '0;
            overflow_reg   <= 1'b0;
            dump_valid_reg <= 1'b0;
            dump_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            wptr_reg       <= wptr_next;
            count_reg      <= count_next;
            rptr_reg       <= rptr_next;
            overflow_reg   <= overflow_next;
            dump_valid_reg <= dump_valid_next;
            dump_addr_reg  <= dump_addr_next;
        end
    end

    vec_capture_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wptr_reg),
        .wdata(bus.in_data),
        .re   (re),
        .raddr(rptr_reg[AW-1:0]),
        .rdata(rdata)
    );

    assign bus.in_ready   = (state_reg == CAPTURE);
    assign bus.full       = (count_reg == DEPTH_C);
    assign bus.count      = count_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.dump_valid = dump_valid_reg;
    assign bus.dump_addr  = dump_addr_reg;
    assign bus.dump_data  = rdata;
endmodule
